// File: rtl/cpu_datapath_pkg.sv
// datapath_pkg: shared width, bus-source priority order and ALU op encoding.
package datapath_pkg;
  localparam int WIDTH = 32;
  typedef enum logic [2:0] {
    SRC_PC   = 3'd0,
    SRC_MDR  = 3'd1,
    SRC_R2   = 3'd2,
    SRC_R3   = 3'd3,
    SRC_ZLO  = 3'd4,
    SRC_ZHI  = 3'd5,
    SRC_NONE = 3'd6
  } bus_src_e;
  localparam bus_src_e BUS_PRIO [0:5] = '{SRC_PC, SRC_MDR, SRC_R2, SRC_R3, SRC_ZLO, SRC_ZHI};
  typedef enum logic [1:0] {OP_NONE, OP_AND, OP_INC} alu_op_e;
endpackage

// File: rtl/cpu_datapath_reg32.sv
// reg32: load-enabled register with synchronous active-low clear.
module reg32 #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clock)
    if (!clear) q <= '0;
    else if (en) q <= d;
endmodule

// File: rtl/cpu_datapath.sv
// cpu_datapath: shared-bus CPU datapath driven entirely by external control strobes.
module cpu_datapath
  import datapath_pkg::*;
#(
  parameter int WIDTH = datapath_pkg::WIDTH
) (
  input  logic               clock,
  input  logic               clear,
  input  logic [WIDTH-1:0]   Mdatain,
  input  logic               Read,
  input  logic               MDRin,
  input  logic               IRin,
  input  logic               Yin,
  input  logic               R1in,
  input  logic               R2in,
  input  logic               R3in,
  input  logic               HIin,
  input  logic               MARin,
  input  logic               PCin,
  input  logic               Zin,
  input  logic               PCout,
  input  logic               MDRout,
  input  logic               R2out,
  input  logic               R3out,
  input  logic               Zlowout,
  input  logic               ZHighout,
  input  logic               AND,
  input  logic               IncPc,
  output logic [WIDTH-1:0]   bus,
  output logic [WIDTH-1:0]   pc_q,
  output logic [WIDTH-1:0]   ir_q,
  output logic [WIDTH-1:0]   mar_q,
  output logic [WIDTH-1:0]   mdr_q,
  output logic [WIDTH-1:0]   y_q,
  output logic [WIDTH-1:0]   r1_q,
  output logic [WIDTH-1:0]   r2_q,
  output logic [WIDTH-1:0]   r3_q,
  output logic [WIDTH-1:0]   hi_q,
  output logic [2*WIDTH-1:0] z_q
);
  logic [5:0]         strobe;
  bus_src_e           src;
  alu_op_e            op;
  logic [2*WIDTH-1:0] c_d;
  logic [WIDTH-1:0]   mdr_d;
  logic               z_en;
  always_comb begin
    strobe = {ZHighout, Zlowout, R3out, R2out, MDRout, PCout};
    src = SRC_NONE;
    for (int i = 5; i >= 0; i--)
      if (strobe[BUS_PRIO[i]]) src = BUS_PRIO[i];
    bus = src == SRC_PC  ? pc_q :
          src == SRC_MDR ? mdr_q :
          src == SRC_R2  ? r2_q :
          src == SRC_R3  ? r3_q :
          src == SRC_ZLO ? z_q[WIDTH-1:0] :
          src == SRC_ZHI ? z_q[2*WIDTH-1:WIDTH] : '0;
  end
  always_comb begin
    op = AND ? OP_AND : IncPc ? OP_INC : OP_NONE;
    c_d = op == OP_AND ? {{WIDTH{1'b0}}, y_q & bus} :
          op == OP_INC ? {{WIDTH{1'b0}}, bus + WIDTH'(1)} : '0;
    mdr_d = Read ? Mdatain : bus;
    z_en = Zin | AND | IncPc;
  end
  reg32 #(.W(WIDTH)) u_pc  (.clock(clock), .clear(clear), .en(PCin),  .d(bus),   .q(pc_q));
  reg32 #(.W(WIDTH)) u_ir  (.clock(clock), .clear(clear), .en(IRin),  .d(bus),   .q(ir_q));
  reg32 #(.W(WIDTH)) u_mar (.clock(clock), .clear(clear), .en(MARin), .d(bus),   .q(mar_q));
  reg32 #(.W(WIDTH)) u_mdr (.clock(clock), .clear(clear), .en(MDRin), .d(mdr_d), .q(mdr_q));
  reg32 #(.W(WIDTH)) u_y   (.clock(clock), .clear(clear), .en(Yin),   .d(bus),   .q(y_q));
  reg32 #(.W(WIDTH)) u_r1  (.clock(clock), .clear(clear), .en(R1in),  .d(bus),   .q(r1_q));
  reg32 #(.W(WIDTH)) u_r2  (.clock(clock), .clear(clear), .en(R2in),  .d(bus),   .q(r2_q));
  reg32 #(.W(WIDTH)) u_r3  (.clock(clock), .clear(clear), .en(R3in),  .d(bus),   .q(r3_q));
  reg32 #(.W(WIDTH)) u_hi  (.clock(clock), .clear(clear), .en(HIin),  .d(bus),   .q(hi_q));
  reg32 #(.W(WIDTH)) u_zlo (.clock(clock), .clear(clear), .en(z_en),  .d(c_d[WIDTH-1:0]),       .q(z_q[WIDTH-1:0]));
  reg32 #(.W(WIDTH)) u_zhi (.clock(clock), .clear(clear), .en(z_en),  .d(c_d[2*WIDTH-1:WIDTH]), .q(z_q[2*WIDTH-1:WIDTH]));
endmodule

// File: tb/tb_cpu_datapath.sv
// tb_cpu_datapath: scoreboard bench for the shared-bus datapath.
module tb_cpu_datapath;
  logic clock = 0, clear = 0;
  logic [31:0] Mdatain = '0;
  logic Read, MDRin, IRin, Yin, R1in, R2in, R3in, HIin, MARin, PCin, Zin;
  logic PCout, MDRout, R2out, R3out, Zlowout, ZHighout, and_s, IncPc;
  logic [31:0] bus, pc_q, ir_q, mar_q, mdr_q, y_q, r1_q, r2_q, r3_q, hi_q;
  logic [63:0] z_q;
  int n_vec = 0, n_bad = 0;
  typedef enum int {S_BUS, S_PC, S_IR, S_MAR, S_MDR, S_Y, S_R1, S_R2, S_R3, S_HI, S_Z} sel_e;
  typedef struct {string tag; sel_e sel; logic [63:0] exp;} exp_t;
  exp_t sb[$];
  cpu_datapath dut (
    .clock(clock), .clear(clear), .Mdatain(Mdatain), .Read(Read),
    .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .R1in(R1in), .R2in(R2in), .R3in(R3in),
    .HIin(HIin), .MARin(MARin), .PCin(PCin), .Zin(Zin),
    .PCout(PCout), .MDRout(MDRout), .R2out(R2out), .R3out(R3out),
    .Zlowout(Zlowout), .ZHighout(ZHighout), .AND(and_s), .IncPc(IncPc),
    .bus(bus), .pc_q(pc_q), .ir_q(ir_q), .mar_q(mar_q), .mdr_q(mdr_q), .y_q(y_q),
    .r1_q(r1_q), .r2_q(r2_q), .r3_q(r3_q), .hi_q(hi_q), .z_q(z_q)
  );
  always #5 clock = ~clock;
  function automatic logic [63:0] obs(sel_e s);
    case (s)
      S_BUS: return {32'h0, bus};
      S_PC:  return {32'h0, pc_q};
      S_IR:  return {32'h0, ir_q};
      S_MAR: return {32'h0, mar_q};
      S_MDR: return {32'h0, mdr_q};
      S_Y:   return {32'h0, y_q};
      S_R1:  return {32'h0, r1_q};
      S_R2:  return {32'h0, r2_q};
      S_R3:  return {32'h0, r3_q};
      S_HI:  return {32'h0, hi_q};
      default: return z_q;
    endcase
  endfunction
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic push(input string tag, input sel_e s, input logic [63:0] exp);
    exp_t e;
    e.tag = tag; e.sel = s; e.exp = exp;
    sb.push_back(e);
  endtask
  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, obs(e.sel), e.exp);
    end
  endtask
  task automatic idle();
    {Read, MDRin, IRin, Yin, R1in, R2in, R3in, HIin, MARin, PCin, Zin} = '0;
    {PCout, MDRout, R2out, R3out, Zlowout, ZHighout, and_s, IncPc} = '0;
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
    drain();
    idle();
  endtask
  task automatic settle();
    #1;
    drain();
  endtask
  task automatic mem_load(input logic [31:0] v);
    Mdatain = v; Read = 1; MDRin = 1;
    tick();
    MDRout = 1;
  endtask
  initial begin
    idle();
    repeat (2) @(posedge clock);
    #1;
    clear = 1;
    mem_load(32'hAAAA_AAAA);
    {PCin, IRin, MARin, Yin, R1in, R2in, R3in, HIin} = '1;
    IncPc = 1;
    push("pre_pc", S_PC, 64'hAAAA_AAAA);
    push("pre_z", S_Z, 64'hAAAA_AAAB);
    tick();
    clear = 0;
    {PCin, IRin, MARin, MDRin, Yin, R1in, R2in, R3in, HIin, Zin} = '1;
    MDRout = 1;
    IncPc = 1;
    for (int s = S_PC; s <= S_Z; s++) push($sformatf("rst_%0d", s), sel_e'(s), 64'h0);
    tick();
    clear = 1;
    push("rst_bus", S_BUS, 64'h0);
    settle();
    mem_load(32'h12); R2in = 1; push("ld_r2", S_R2, 64'h12); tick();
    mem_load(32'h14); R3in = 1; push("ld_r3", S_R3, 64'h14); tick();
    mem_load(32'h18); R1in = 1; push("ld_r1", S_R1, 64'h18); tick();
    R2out = 1; Yin = 1; push("and_y", S_Y, 64'h12); tick();
    R3out = 1; and_s = 1; push("and_z", S_Z, {32'h0, 32'h12 & 32'h14}); tick();
    Zlowout = 1; R1in = 1; push("and_r1", S_R1, 64'h10); tick();
    ZHighout = 1; HIin = 1; push("and_hi", S_HI, 64'h0); tick();
    mem_load(32'hFFFF_FFFF); PCin = 1; push("pc_max", S_PC, 64'hFFFF_FFFF); tick();
    PCout = 1; IncPc = 1; push("inc_wrap_z", S_Z, 64'h0); tick();
    Zlowout = 1; PCin = 1; push("inc_wrap_pc", S_PC, 64'h0); tick();
    mem_load(32'h5); PCin = 1; tick();
    PCout = 1; IncPc = 1; push("inc_z", S_Z, 64'h6); tick();
    Zlowout = 1; PCin = 1; push("inc_pc", S_PC, 64'h6); tick();
    PCout = 1; R2out = 1; push("prio_pc_r2", S_BUS, 64'h6); settle(); idle();
    MDRout = 1; R2out = 1; push("prio_mdr_r2", S_BUS, 64'h5); settle(); idle();
    R3out = 1; Zlowout = 1; push("prio_r3_zlo", S_BUS, 64'h14); settle(); idle();
    Zlowout = 1; ZHighout = 1; push("prio_zlo_zhi", S_BUS, 64'h6); settle(); idle();
    ZHighout = 1; push("bus_zhi", S_BUS, 64'h0); settle(); idle();
    push("bus_idle", S_BUS, 64'h0); settle();
    MDRin = 1; Read = 0; R3out = 1; push("mdr_bus", S_MDR, 64'h14); tick();
    Mdatain = 32'hDEAD_BEEF; MDRin = 1; Read = 1; R3out = 1;
    push("mdr_mem", S_MDR, 64'hDEAD_BEEF); tick();
    R2out = 1; R2in = 1; push("self_r2", S_R2, 64'h12); tick();
    R2out = 1; Yin = 1; tick();
    R3out = 1; and_s = 1; IncPc = 1; push("and_wins", S_Z, 64'h10); tick();
    check("sb_empty", 64'(sb.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/cpu_datapath.md
# cpu_datapath

Phase-1 CPU datapath of the `datapath` module: a single 32-bit shared bus joining program counter, instruction register, memory interface registers (MAR/MDR), three general registers R1–R3, the ALU operand latch Y, the 64-bit result register Z and the HI register. Every transfer is driven cycle by cycle by externally supplied control strobes, either from the control unit or from a bench. The block contains no sequencing logic of its own. All state is observable through debug outputs.

## Interface
Parameters:
- `WIDTH`, 32, bus and register width (Z is 2*WIDTH).

Ports:
- `clock`  in  1  rising-edge clock for all state.
- `clear`  in  1  synchronous, active-low reset.
- `Mdatain`  in  32  memory read data.
- `Read`  in  1  MDR input select: 1 selects Mdatain, 0 selects the bus.
- Load enables, each `in 1`, sampled at posedge: `MDRin`, `IRin`, `Yin`, `R1in`, `R2in`, `R3in`, `HIin`, `MARin`, `PCin`, `Zin`.
- Bus drive strobes, each `in 1`: `PCout`, `MDRout`, `R2out`, `R3out`, `Zlowout`, `ZHighout`.
- ALU op strobes, each `in 1`: `AND`, `IncPc`.
- Debug outputs, each `out 32`: `bus`, `pc_q`, `ir_q`, `mar_q`, `mdr_q`, `y_q`, `r1_q`, `r2_q`, `r3_q`, `hi_q`.
- `z_q`  out  64  Z register.

## Operation
- The bus is a combinational mux. Priority when several strobes are high: PCout > MDRout > R2out > R3out > Zlowout > ZHighout.
  - No strobe high: bus = 0.
  - Zlowout drives Z[31:0]; ZHighout drives Z[63:32].
- At posedge, each register with its enable high loads the bus. MDR is the exception: it loads Read ? Mdatain : bus.
- ALU result C (64 bits) is combinational:
  - AND: C = {32'h0, Y & bus}.
  - IncPc: C = {32'h0, bus + 1}, modulo 2^32, so 0xFFFFFFFF wraps to 0.
  - Both asserted: AND wins.
  - Neither asserted: C = 0.
- Z loads C at posedge when Zin, AND or IncPc is high. An ALU op strobe alone therefore captures its result without Zin.
- Z holds its value otherwise. Z can be read back on the bus the following cycle.
- Simultaneous read and write of the same register in one cycle: the register reads its old value onto the bus and loads the bus value at the edge, so a self-transfer is a no-op.
- Control inputs left unconnected (z/x) carry no defined behaviour. The integrator ties them to 0.

## Timing
- Synchronous reset: `clear`=0 at a posedge zeroes every register (PC, IR, MAR, MDR, Y, R1–R3, HI, Z), regardless of enables. Reset dominates a load in the same cycle.
- After reset, `bus`=0 until a strobe is asserted.
- Register-to-register transfer: 1 cycle. Enables are set up before the posedge; the destination updates at that edge.
- Memory load (Mdatain → MDR → Rn): 2 cycles.
- ALU op: load Y in cycle n; assert the second operand's out strobe plus the op in cycle n+1, so Z updates at the end of n+1. Z→Rn transfers in cycle n+2.
- `clear` deassertion takes effect at the next edge. No mid-operation state survives a reset.

## Structure
- Shared package `datapath_pkg`:
  - `WIDTH` constant.
  - Bus-source priority order as a localparam list.
  - ALU op enum {OP_NONE, OP_AND, OP_INC}.
- One sub-module `reg32`: `clock`, `clear` (sync, active-low), `en`, `d[31:0]`, `q[31:0]`. It is instantiated for PC, IR, MAR, MDR, Y, R1–R3 and HI; Z uses two instances.
- Bus mux and ALU are coded inline in `datapath`.

## Test plan
- Reset: drive all registers nonzero, then hold `clear`=0 for one edge → all debug outputs read 0.
- Register loads:
  - Mdatain=0x12, Read=MDRin=1; next cycle MDRout=R2in=1 → r2_q=0x12.
  - Same sequence with Mdatain=0x14 into R3 → r3_q=0x14.
  - Same sequence with Mdatain=0x18 into R1 → r1_q=0x18.
- AND: R2out+Yin; then R3out+AND → z_q=0x10. Then Zlowout+R1in → r1_q=0x10. Then ZHighout+HIin → hi_q=0.
- IncPc: PC=0xFFFFFFFF; PCout+IncPc; then Zlowout+PCin → pc_q=0. A second run from PC=5 gives pc_q=6.
- Bus priority: PCout and R2out both high → bus equals pc_q. No strobes high → bus=0.
- Read mux: MDRin=1 with Read=0 and R3out=1 → mdr_q=r3_q. With Read=1 → mdr_q=Mdatain.
